// File: rtl/uart_transmit_controller.sv
// uart_transmit_controller
// 8N1 UART transmitter. The host pushes bytes through a Load/Full handshake
// into a small circular FIFO. Each byte is then shifted out LSB-first on
// UART_TX_O, holding every bit for CLOCK_RATE Clock_50 cycles. Frames that are
// already queued go out back-to-back, with no idle cycle between them.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity slot follows data bit 7 (8E1 framing)
//   undefined -> plain 8N1 framing, and the parity state is absent
//
// state            | meaning
// S_TXC_IDLE       | line idle high, waiting for Enable and a queued byte
// S_TXC_START_BIT  | line driven low for one bit period
// S_TXC_DATA       | shift register LSB driven, 8 bit periods
// S_TXC_PARITY     | even parity of the byte, one bit period (macro only)
// S_TXC_STOP_BIT   | line high for one bit period, may chain to next frame

module uart_transmit_controller #(
  parameter int CLOCK_RATE = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Load,
  input  logic [7:0] TX_data,
  output logic       Full,
  output logic       Empty,
  output logic       Busy,
  output logic       Overflow,
  output logic       UART_TX_O
);

  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [9:0]     BIT_LAST = 10'(CLOCK_RATE - 1);
  localparam logic [9:0]     BIT_ONE  = 10'd1;
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_TXC_IDLE      = 3'd0,
    S_TXC_START_BIT = 3'd1,
    S_TXC_DATA      = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_TXC_PARITY    = 3'd3,
`endif
    S_TXC_STOP_BIT  = 3'd4
  } txc_state_t;

  txc_state_t    state, state_next;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop;

  logic [9:0]    bit_cnt;
  logic [2:0]    data_cnt;
  logic [7:0]    shift_reg;
  logic          bit_done;
  logic          tx_next;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  // Full is the registered value, so a push in the same cycle as a pop is still dropped
  assign push     = Load & ~Full;
  assign bit_done = (bit_cnt == BIT_LAST);

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // FIFO pointers, occupancy and registered status flags
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      Full     <= (count_next == CNT_FULL);
      Empty    <= (count_next == '0);
      Overflow <= Load & Full;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed
  always_ff @(posedge Clock_50) begin
    if (push) fifo_mem[wr_ptr] <= TX_data;
  end

  // FSM state register
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) state <= S_TXC_IDLE;
    else         state <= state_next;
  end

  // FSM next state and FIFO pop decision
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_TXC_IDLE: begin
        if (Enable && !Empty) begin
          pop        = 1'b1;
          state_next = S_TXC_START_BIT;
        end
      end
      S_TXC_START_BIT: begin
        if (bit_done) state_next = S_TXC_DATA;
      end
      S_TXC_DATA: begin
        if (bit_done && data_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_TXC_PARITY;
`else
          state_next = S_TXC_STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_TXC_PARITY: begin
        if (bit_done) state_next = S_TXC_STOP_BIT;
      end
`endif
      S_TXC_STOP_BIT: begin
        if (bit_done) begin
          if (Enable && !Empty) begin
            pop        = 1'b1;
            state_next = S_TXC_START_BIT;
          end else begin
            state_next = S_TXC_IDLE;
          end
        end
      end
      default: state_next = S_TXC_IDLE;
    endcase
  end

  // Line level for the current state; registered below, so the pin lags the state by one cycle
  always_comb begin
    tx_next = 1'b1;
    case (state)
      S_TXC_IDLE:      tx_next = 1'b1;
      S_TXC_START_BIT: tx_next = 1'b0;
      S_TXC_DATA:      tx_next = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      S_TXC_PARITY:    tx_next = parity_bit;
`endif
      S_TXC_STOP_BIT:  tx_next = 1'b1;
      default:         tx_next = 1'b1;
    endcase
  end

  // Registered serial line and busy flag
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      UART_TX_O <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      UART_TX_O <= tx_next;
      Busy      <= (state_next != S_TXC_IDLE);
    end
  end

  // Bit timer, data bit counter and shift register
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      bit_cnt   <= '0;
      data_cnt  <= '0;
      shift_reg <= '0;
    end else if (pop) begin
      bit_cnt   <= '0;
      data_cnt  <= '0;
      shift_reg <= fifo_mem[rd_ptr];
    end else if (state != S_TXC_IDLE) begin
      if (bit_done) bit_cnt <= '0;
      else          bit_cnt <= bit_cnt + BIT_ONE;
      if (state == S_TXC_DATA && bit_done) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        data_cnt  <= data_cnt + 3'd1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at pop time because shifting destroys the byte
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn)  parity_bit <= 1'b0;
    else if (pop) parity_bit <= ^fifo_mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_uart_transmit_controller.sv
// Testbench for uart_transmit_controller. Queued bytes are predicted into a
// scoreboard, and a line monitor decodes every frame cycle by cycle.
module tb_uart_transmit_controller;

  localparam int CR    = 6;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CR;

  logic       Clock_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       Enable   = 1'b0;
  logic       Load     = 1'b0;
  logic [7:0] TX_data  = 8'h00;
  logic       Full, Empty, Busy, Overflow, UART_TX_O;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         frame_start[$];

  uart_transmit_controller #(.CLOCK_RATE(CR), .FIFO_DEPTH(DEPTH)) dut (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .Enable   (Enable),
    .Load     (Load),
    .TX_data  (TX_data),
    .Full     (Full),
    .Empty    (Empty),
    .Busy     (Busy),
    .Overflow (Overflow),
    .UART_TX_O(UART_TX_O)
  );

  always #5 Clock_50 = ~Clock_50;
  always @(posedge Clock_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ideal line level in a given bit slot of a frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (NBITS == 11 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  // Monitor: decodes each frame and compares it with the scoreboard head
  initial begin : monitor
    logic [7:0] exp_b, got;
    int         errs;
    bit         aborted;
    forever begin
      @(negedge Clock_50);
      if (Resetn === 1'b1 && UART_TX_O === 1'b0) begin
        frame_start.push_back(cyc);
        check("frame_expected", exp_q.size() != 0, 1);
        exp_b   = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        got     = 8'h00;
        errs    = 0;
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge Clock_50);
          if (Resetn !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (UART_TX_O !== frame_bit(exp_b, i / CR)) errs++;
          if ((i % CR) == CR / 2 && i / CR >= 1 && i / CR <= 8) got[i/CR-1] = UART_TX_O;
        end
        if (!aborted) begin
          check("frame_byte", got, exp_b);
          check("frame_timing_errs", errs, 0);
        end
      end
    end
  end

  // One Load strobe, called at a negedge; returns at the negedge after the sampling edge
  task automatic push_byte(input logic [7:0] b, input bit accept);
    Load    = 1'b1;
    TX_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge Clock_50);
    Load = 1'b0;
    check("overflow_flag", Overflow, !accept);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(Empty === 1'b1 && Busy === 1'b0) && n < budget) begin
      @(negedge Clock_50);
      n++;
    end
    check("drain_in_time", n < budget, 1);
    repeat (4) @(negedge Clock_50);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic wait_new_frame(input int n0, input int budget);
    int n = 0;
    while (frame_start.size() <= n0 && n < budget) begin
      @(negedge Clock_50);
      n++;
    end
    check("frame_started_in_time", n < budget, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         cN, s0, ones, n0, occ, nb;
    bit         acc;
    logic [7:0] b;

    // Reset values
    repeat (3) @(negedge Clock_50);
    check("rst_tx", UART_TX_O, 1);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_busy", Busy, 0);
    check("rst_overflow", Overflow, 0);
    Resetn = 1'b1;
    @(negedge Clock_50);

    // Single byte: latency, frame shape and Busy length
    Enable = 1'b1;
    push_byte(8'hA5, 1);
    cN = cyc;
    check("t1_empty_after_load", Empty, 0);
    check("t1_line_idle", UART_TX_O, 1);
    ones = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge Clock_50);
      if (Busy === 1'b1) ones++;
      if (i == 0) check("t1_line_n1", UART_TX_O, 1);
      if (i == 1) check("t1_line_n2", UART_TX_O, 0);
    end
    check("t1_busy_cycles", ones, FRAME);
    check("t1_empty_end", Empty, 1);
    check("t1_busy_end", Busy, 0);
    check("t1_start_latency", frame_start[frame_start.size()-1] - cN, 2);

    // Four queued bytes: Full, then back-to-back frames
    Enable = 1'b0;
    push_byte(8'h00, 1);
    push_byte(8'hFF, 1);
    push_byte(8'h55, 1);
    check("t2_not_full_at_3", Full, 0);
    push_byte(8'h3C, 1);
    check("t2_full_at_4", Full, 1);
    n0 = frame_start.size();
    Enable = 1'b1;
    @(negedge Clock_50);
    check("t2_full_drops_after_pop", Full, 0);
    wait_drain(600);
    check("t2_frame_count", frame_start.size() - n0, 4);
    for (int k = 1; k < 4; k++)
      check("t2_back_to_back", frame_start[n0+k] - frame_start[n0+k-1], FRAME);

    // Overflow while full and transmitting
    Enable = 1'b0;
    push_byte(8'h11, 1);
    push_byte(8'h22, 1);
    push_byte(8'h33, 1);
    push_byte(8'h44, 1);
    Enable = 1'b1;
    repeat (5) @(negedge Clock_50);
    push_byte(8'h88, 1);
    check("t3_full_refilled", Full, 1);
    push_byte(8'h77, 0);
    @(negedge Clock_50);
    check("t3_overflow_one_cycle", Overflow, 0);
    check("t3_still_full", Full, 1);
    wait_drain(800);

    // Enable gating
    Enable = 1'b0;
    push_byte(8'h12, 1);
    push_byte(8'h34, 1);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock_50);
      if (UART_TX_O === 1'b1) ones++;
    end
    check("t4_line_held_high", ones, 20);
    check("t4_empty_held", Empty, 0);
    n0 = frame_start.size();
    s0 = cyc;
    Enable = 1'b1;
    wait_new_frame(n0, 50);
    if (frame_start.size() > n0) check("t4_enable_latency", frame_start[n0] - s0, 2);
    repeat (20) @(negedge Clock_50);
    Enable = 1'b0;
    begin
      int n = 0;
      while (Busy !== 1'b0 && n < 200) begin
        @(negedge Clock_50);
        n++;
      end
      check("t4_frame_completed", n < 200, 1);
    end
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock_50);
      if (UART_TX_O === 1'b1) ones++;
    end
    check("t4_next_held_line", ones, 40);
    check("t4_next_held_empty", Empty, 0);
    check("t4_next_held_queue", exp_q.size(), 1);
    Enable = 1'b1;
    wait_drain(300);

    // Reset in the middle of data bit 3
    push_byte(8'hC3, 1);
    push_byte(8'h5A, 1);
    n0 = frame_start.size();
    wait_new_frame(n0, 50);
    repeat (4 * CR + 2) @(negedge Clock_50);
    #2 Resetn = 1'b0;
    #1;
    check("t5_rst_tx", UART_TX_O, 1);
    check("t5_rst_empty", Empty, 1);
    check("t5_rst_full", Full, 0);
    check("t5_rst_busy", Busy, 0);
    exp_q.delete();
    repeat (3) @(negedge Clock_50);
    Resetn = 1'b1;
    @(negedge Clock_50);
    push_byte(8'h81, 1);
    wait_drain(300);

`ifdef UART_TX_PARITY_EN
    // Parity slot values and frame length
    n0 = frame_start.size();
    push_byte(8'h07, 1);
    push_byte(8'h03, 1);
    wait_drain(400);
    check("tp_frame_count", frame_start.size() - n0, 2);
    if (frame_start.size() >= n0 + 2)
      check("tp_frame_len", frame_start[n0+1] - frame_start[n0], 66);
`endif

    // Randomized bursts checked against an occupancy model
    for (int it = 0; it < 8; it++) begin
      Enable = 1'b0;
      occ = 0;
      nb  = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        b   = 8'($urandom);
        acc = (occ < DEPTH);
        push_byte(b, acc);
        if (acc) occ++;
        check("rnd_full", Full, occ == DEPTH);
        check("rnd_empty", Empty, occ == 0);
      end
      repeat ($urandom_range(0, 5)) @(negedge Clock_50);
      Enable = 1'b1;
      wait_drain(nb * FRAME + 200);
    end

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
